// File: rtl/register_block_arb.sv
// Shared register file with round-robin arbitration across N_CHAN command masters.
// One access per cycle; per-word strobes, read-only mask and address-error flags.
module register_block_arb #(
  parameter int WORD_WIDTH = 8,
  parameter int REG_WIDTH  = 4,
  parameter int REG_DEPTH  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int N_CHAN     = 2,
  parameter logic [REG_DEPTH-1:0] RO_MASK = '0,
  localparam int DATA_W = WORD_WIDTH * REG_WIDTH
) (
  input  logic                         clk,
  input  logic                         i_reset_n,
  input  logic [N_CHAN-1:0]            i_w_en,
  input  logic [N_CHAN*ADDR_WIDTH-1:0] i_w_addr,
  input  logic [N_CHAN*DATA_W-1:0]     i_w_value,
  input  logic [N_CHAN*REG_WIDTH-1:0]  i_w_strb,
  input  logic [N_CHAN-1:0]            i_r_en,
  input  logic [N_CHAN*ADDR_WIDTH-1:0] i_r_addr,
  output logic [N_CHAN*DATA_W-1:0]     o_r_value,
  output logic [N_CHAN-1:0]            o_r_valid,
  output logic [N_CHAN-1:0]            o_ack,
  output logic [N_CHAN-1:0]            o_err,
  output logic [DATA_W-1:0]            o_mem [REG_DEPTH]
);

  localparam int PW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int IW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic [PW-1:0]           ptr_q, ptr_d;
  logic [N_CHAN-1:0]       ack_q, rvalid_q, err_q;
  logic [N_CHAN*DATA_W-1:0] rvalue_q;
  logic [DATA_W-1:0]       mem_q [REG_DEPTH];

  logic [N_CHAN-1:0]       elig;
  logic                    gnt_vld;
  logic [PW-1:0]           gnt;
  logic                    g_wr;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_W-1:0]       g_wdata;
  logic [REG_WIDTH-1:0]    g_strb;
  logic [IW-1:0]           g_idx;
  logic                    in_rng;
  logic                    g_err;
  logic                    wr_ok;
  logic [DATA_W-1:0]       wr_word;
  logic [DATA_W-1:0]       rd_word;

  // Round-robin search: walk from ptr upward; descending loop lets the nearest win.
  always_comb begin
    elig    = (i_w_en | i_r_en) & ~ack_q;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = N_CHAN - 1; k >= 0; k--) begin
      if (elig[PW'((int'(ptr_q) + k) % N_CHAN)]) begin
        gnt_vld = 1'b1;
        gnt     = PW'((int'(ptr_q) + k) % N_CHAN);
      end
    end
    ptr_d = gnt_vld ? PW'((int'(gnt) + 1) % N_CHAN) : ptr_q;
  end

  // Decode the granted channel's request; a pending write shadows its read.
  always_comb begin
    g_wr    = i_w_en[gnt];
    g_wdata = i_w_value[int'(gnt)*DATA_W +: DATA_W];
    g_strb  = i_w_strb[int'(gnt)*REG_WIDTH +: REG_WIDTH];
    g_addr  = g_wr ? i_w_addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH]
                   : i_r_addr[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH];
    in_rng  = 32'(g_addr) < 32'(REG_DEPTH);
    g_idx   = g_addr[IW-1:0];
    g_err   = g_wr ? (!in_rng || RO_MASK[g_idx]) : !in_rng;
    wr_ok   = gnt_vld && g_wr && !g_err;
    rd_word = in_rng ? mem_q[g_idx] : '0;
    wr_word = mem_q[g_idx];
    for (int w = 0; w < REG_WIDTH; w++) begin
      if (g_strb[w]) begin
        wr_word[w*WORD_WIDTH +: WORD_WIDTH] = g_wdata[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Arbiter pointer and one-cycle completion flags for the granted channel.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q    <= '0;
      ack_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rvalue_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      ack_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      if (gnt_vld) begin
        ack_q[gnt] <= 1'b1;
        err_q[gnt] <= g_err;
        if (!g_wr) begin
          rvalid_q[gnt] <= 1'b1;
          rvalue_q[int'(gnt)*DATA_W +: DATA_W] <= rd_word;
        end
      end
    end
  end

  // Register array; only a legal write touches it, merged word by word.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int r = 0; r < REG_DEPTH; r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[g_idx] <= wr_word;
    end
  end

  assign o_ack     = ack_q;
  assign o_r_valid = rvalid_q;
  assign o_err     = err_q;
  assign o_r_value = rvalue_q;
  assign o_mem     = mem_q;

endmodule

// File: tb/tb_register_block_arb.sv
// Bench for register_block_arb: directed vector table, contention and reset
// sequences, then random traffic against a transaction-level model.
module tb_register_block_arb;
  localparam int NC = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD = 16;
  localparam logic [15:0] RO = 16'h0004;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC-1:0] w_en, r_en, r_valid, ack, err;
  logic [NC*AW-1:0] w_addr, r_addr;
  logic [NC*DW-1:0] w_value, r_value;
  logic [NC*4-1:0] w_strb;
  logic [DW-1:0] mem [RD];

  int checks = 0;
  int failures = 0;

  register_block_arb #(
    .WORD_WIDTH(8), .REG_WIDTH(4), .REG_DEPTH(RD),
    .ADDR_WIDTH(AW), .N_CHAN(NC), .RO_MASK(RO)
  ) dut (
    .clk(clk), .i_reset_n(rst_n),
    .i_w_en(w_en), .i_w_addr(w_addr), .i_w_value(w_value), .i_w_strb(w_strb),
    .i_r_en(r_en), .i_r_addr(r_addr),
    .o_r_value(r_value), .o_r_valid(r_valid), .o_ack(ack), .o_err(err),
    .o_mem(mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] we; logic [7:0] wa0; logic [31:0] wv0; logic [3:0] s0;
    logic [7:0] wa1; logic [31:0] wv1; logic [3:0] s1;
    logic [1:0] re; logic [7:0] ra0; logic [7:0] ra1;
    logic [1:0] ak; logic [1:0] er; logic [1:0] rv;
    logic [31:0] rv0; logic [31:0] rv1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [1:0] we, logic [7:0] wa0, logic [31:0] wv0, logic [3:0] s0,
    logic [7:0] wa1, logic [31:0] wv1, logic [3:0] s1,
    logic [1:0] re, logic [7:0] ra0, logic [7:0] ra1,
    logic [1:0] ak, logic [1:0] er, logic [1:0] rv,
    logic [31:0] rv0, logic [31:0] rv1);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wv0 = wv0; v.s0 = s0;
    v.wa1 = wa1; v.wv1 = wv1; v.s1 = s1;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1;
    v.ak = ak; v.er = er; v.rv = rv; v.rv0 = rv0; v.rv1 = rv1;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] rv0, logic [31:0] rv1);
    return mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0,
              2'b00, 8'h0, 8'h0, 2'b00, 2'b00, 2'b00, rv0, rv1);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    w_en = '0; r_en = '0; w_addr = '0; r_addr = '0;
    w_value = '0; w_strb = '0;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [RD];
  int          m_ptr;
  logic [1:0]  m_ack;
  logic [1:0]  e_ack, e_err, e_rvl;
  logic [31:0] e_rv [NC];

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_ptr = 0; m_ack = '0; e_rv[0] = '0; e_rv[1] = '0;
  endtask

  task automatic model_step();
    int order[$];
    int g;
    logic [7:0] a;
    logic [31:0] w;
    e_ack = '0; e_err = '0; e_rvl = '0;
    for (int k = 0; k < NC; k++) order.push_back((m_ptr + k) % NC);
    g = -1;
    foreach (order[k]) begin
      if (g < 0 && (w_en[order[k]] || r_en[order[k]]) && !m_ack[order[k]])
        g = order[k];
    end
    if (g >= 0) begin
      e_ack[g] = 1'b1;
      m_ptr = (g + 1) % NC;
      if (w_en[g]) begin
        a = w_addr[g*AW +: AW];
        if (a >= RD || RO[a[3:0]]) begin
          e_err[g] = 1'b1;
        end else begin
          w = m_mem[a];
          for (int b = 0; b < 4; b++)
            if (w_strb[g*4+b]) w[b*8 +: 8] = w_value[g*DW + b*8 +: 8];
          m_mem[a] = w;
        end
      end else begin
        a = r_addr[g*AW +: AW];
        e_rvl[g] = 1'b1;
        if (a >= RD) begin
          e_err[g] = 1'b1;
          e_rv[g] = '0;
        end else begin
          e_rv[g] = m_mem[a];
        end
      end
    end
    m_ack = e_ack;
  endtask

  task automatic model_cmp(string tag);
    int bad;
    chk({tag, "_ack"}, 64'(ack), 64'(e_ack));
    chk({tag, "_err"}, 64'(err), 64'(e_err));
    chk({tag, "_rvalid"}, 64'(r_valid), 64'(e_rvl));
    chk({tag, "_rvalue"}, 64'(r_value), {e_rv[1], e_rv[0]});
    bad = 0;
    for (int i = 0; i < RD; i++) if (mem[i] !== m_mem[i]) bad++;
    chk({tag, "_mem_mismatch_regs"}, 64'(bad), 64'd0);
  endtask

  task automatic rand_stim();
    for (int c = 0; c < NC; c++) begin
      if (m_ack[c] || !(w_en[c] || r_en[c])) begin
        int kind;
        kind = $urandom_range(0, 9);
        w_en[c] = (kind >= 3 && kind <= 6) || kind == 9;
        r_en[c] = kind >= 7;
        w_addr[c*AW +: AW] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 19));
        r_addr[c*AW +: AW] = ($urandom_range(0, 9) == 0) ? 8'h80 : 8'($urandom_range(0, 19));
        w_value[c*DW +: DW] = $urandom;
        w_strb[c*4 +: 4] = 4'($urandom);
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bad;
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_rvalue", 64'(r_value), 64'd0);
    bad = 0;
    for (int i = 0; i < RD; i++) if (mem[i] !== 32'h0) bad++;
    chk("reset_mem_nonzero", 64'(bad), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors: ptr starts at 0
    tbl.push_back(mk(2'b01, 8'h03, 32'hDEADBEEF, 4'hF, 8'h0, 32'h0, 4'h0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h03, 8'h00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h03, 8'h00, 2'b01, 2'b00, 2'b01, 32'hDEADBEEF, 32'h0));
    tbl.push_back(idle(32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(2'b01, 8'h05, 32'h11223344, 4'hF, 8'h0, 32'h0, 4'h0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0));
    tbl.push_back(idle(32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(2'b01, 8'h05, 32'hAABBCCDD, 4'b0101, 8'h0, 32'h0, 4'h0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h05, 8'h00, 2'b00, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h05, 8'h00, 2'b01, 2'b00, 2'b01, 32'h11BB33DD, 32'h0));
    tbl.push_back(mk(2'b10, 8'h0, 32'h0, 4'h0, 8'h10, 32'hFFFFFFFF, 4'hF, 2'b00, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 32'h11BB33DD, 32'h0));
    tbl.push_back(idle(32'h11BB33DD, 32'h0));
    tbl.push_back(mk(2'b10, 8'h0, 32'h0, 4'h0, 8'h02, 32'h12345678, 4'hF, 2'b00, 8'h00, 8'h00, 2'b10, 2'b10, 2'b00, 32'h11BB33DD, 32'h0));
    tbl.push_back(idle(32'h11BB33DD, 32'h0));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b10, 8'h00, 8'h03, 2'b10, 2'b00, 2'b10, 32'h11BB33DD, 32'hDEADBEEF));
    tbl.push_back(idle(32'h11BB33DD, 32'hDEADBEEF));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b10, 8'h00, 8'hFF, 2'b10, 2'b10, 2'b10, 32'h11BB33DD, 32'h0));
    tbl.push_back(idle(32'h11BB33DD, 32'h0));
    // hazard: write reg7 and read reg7 contend
    tbl.push_back(mk(2'b01, 8'h07, 32'h5, 4'hF, 8'h0, 32'h0, 4'h0, 2'b10, 8'h00, 8'h07, 2'b01, 2'b00, 2'b00, 32'h11BB33DD, 32'h0));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b10, 8'h00, 8'h07, 2'b10, 2'b00, 2'b10, 32'h11BB33DD, 32'h5));
    tbl.push_back(mk(2'b01, 8'h08, 32'h1, 4'hF, 8'h0, 32'h0, 4'h0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 32'h11BB33DD, 32'h5));
    tbl.push_back(mk(2'b01, 8'h07, 32'h9, 4'hF, 8'h0, 32'h0, 4'h0, 2'b10, 8'h00, 8'h07, 2'b10, 2'b00, 2'b10, 32'h11BB33DD, 32'h5));
    tbl.push_back(mk(2'b01, 8'h07, 32'h9, 4'hF, 8'h0, 32'h0, 4'h0, 2'b10, 8'h00, 8'h07, 2'b01, 2'b00, 2'b00, 32'h11BB33DD, 32'h5));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b10, 8'h00, 8'h07, 2'b10, 2'b00, 2'b10, 32'h11BB33DD, 32'h9));
    tbl.push_back(idle(32'h11BB33DD, 32'h9));
    // zero strobe write: acked, no change
    tbl.push_back(mk(2'b01, 8'h08, 32'hFFFFFFFF, 4'h0, 8'h0, 32'h0, 4'h0, 2'b00, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 32'h11BB33DD, 32'h9));
    tbl.push_back(idle(32'h11BB33DD, 32'h9));
    // write and read together on ch0: write first, read after ack cycle
    tbl.push_back(mk(2'b01, 8'h09, 32'h77, 4'hF, 8'h0, 32'h0, 4'h0, 2'b01, 8'h09, 8'h00, 2'b01, 2'b00, 2'b00, 32'h11BB33DD, 32'h9));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h09, 8'h00, 2'b00, 2'b00, 2'b00, 32'h11BB33DD, 32'h9));
    tbl.push_back(mk(2'b00, 8'h0, 32'h0, 4'h0, 8'h0, 32'h0, 4'h0, 2'b01, 8'h09, 8'h00, 2'b01, 2'b00, 2'b01, 32'h77, 32'h9));
    tbl.push_back(idle(32'h77, 32'h9));

    foreach (tbl[i]) begin
      w_en = tbl[i].we; r_en = tbl[i].re;
      w_addr = {tbl[i].wa1, tbl[i].wa0};
      w_value = {tbl[i].wv1, tbl[i].wv0};
      w_strb = {tbl[i].s1, tbl[i].s0};
      r_addr = {tbl[i].ra1, tbl[i].ra0};
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_ack", i), 64'(ack), 64'(tbl[i].ak));
      chk($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].er));
      chk($sformatf("vec%0d_rvalid", i), 64'(r_valid), 64'(tbl[i].rv));
      chk($sformatf("vec%0d_rvalue", i), 64'(r_value), {tbl[i].rv1, tbl[i].rv0});
    end

    chk("mem0_no_alias", 64'(mem[0]), 64'h0);
    chk("mem2_ro_kept", 64'(mem[2]), 64'h0);
    chk("mem3", 64'(mem[3]), 64'hDEADBEEF);
    chk("mem5_strobe", 64'(mem[5]), 64'h11BB33DD);
    chk("mem7", 64'(mem[7]), 64'h9);
    chk("mem8_zero_strb", 64'(mem[8]), 64'h1);
    chk("mem9", 64'(mem[9]), 64'h77);

    // contention: ptr is 1 here, so grants go ch1, ch0, ch1, ...
    for (int k = 0; k < 8; k++) begin
      w_en = 2'b11; r_en = 2'b00; w_strb = 8'hFF;
      w_addr = {8'h0B, 8'h0A};
      w_value = {32'(k + 100), 32'(k)};
      @(posedge clk);
      #1;
      chk($sformatf("contend%0d_ack", k), 64'(ack), (k % 2 == 0) ? 64'h2 : 64'h1);
    end
    chk("contend_mem10", 64'(mem[10]), 64'd7);
    chk("contend_mem11", 64'(mem[11]), 64'd106);

    // asynchronous reset in the middle of a held write on both channels
    w_en = 2'b11; r_en = 2'b00; w_strb = 8'hFF;
    w_addr = {8'h04, 8'h01};
    w_value = {32'h0BADF00D, 32'hCAFEF00D};
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_ack", 64'(ack), 64'd0);
    chk("async_reset_rvalue", 64'(r_value), 64'd0);
    bad = 0;
    for (int i = 0; i < RD; i++) if (mem[i] !== 32'h0) bad++;
    chk("async_reset_mem_nonzero", 64'(bad), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("in_reset_ack", 64'(ack), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    model_step();
    @(posedge clk);
    #1;
    model_cmp("post_reset");
    chk("post_reset_ch0_first", 64'(ack), 64'h1);

    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      rand_stim();
      model_step();
      @(posedge clk);
      #1;
      model_cmp($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
